// File: rtl/fifo_buffer.sv
// Synchronous byte FIFO between the UART receive stage and a downstream consumer.
// Registered read data with a one-cycle rvalid pulse and sticky overflow/underflow flags for debug.
module fifo_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              we,
    output logic              busy,
    input  logic              re,
    output logic [DATA_W-1:0] data_out,
    output logic              rvalid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic              wr_ok;
    logic              rd_ok;

    // Handshake: a write is taken when we=1 and full=0; a read is taken when re=1 and
    // empty=0 and answers with data_out plus a single rvalid pulse after that same edge.
    // Both decisions use the pre-edge count, so a slot freed this cycle cannot take a write.
    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    assign busy  = full;
    assign wr_ok = we & ~full;
    assign rd_ok = re & ~empty;

    // Storage has no reset; entries are only meaningful once written.
    always_ff @(posedge clk) begin
        if (reset && wr_ok) begin
            mem[wp] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            data_out  <= '0;
            rvalid    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rvalid <= rd_ok;
            if (wr_ok) begin
                wp <= wp + 1'b1;
            end
            if (rd_ok) begin
                data_out <= mem[rp];
                rp       <= rp + 1'b1;
            end
            if (we && full) begin
                overflow <= 1'b1;
            end
            if (re && empty) begin
                underflow <= 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed bench for fifo_buffer: a vector table for single-cycle behaviour plus
// scoreboarded sequences for fill/overflow, wrap-around, simultaneous ops and mid-stream reset.
module tb_fifo_buffer;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       we;
    logic       re;
    logic       busy;
    logic [7:0] data_out;
    logic       rvalid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int tests_run;
    int tests_failed;
    logic [7:0] exp_q[$];

    fifo_buffer #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .we        (we),
        .busy      (busy),
        .re        (re),
        .data_out  (data_out),
        .rvalid    (rvalid),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the test ended");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       we;
        logic       re;
        logic [7:0] din;
        logic [7:0] dout;
        logic       rvalid;
        logic [4:0] count;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic drive(input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        we      = w;
        re      = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        we    = 1'b0;
        re    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic do_write(input logic [7:0] d);
        drive(1'b1, 1'b0, d);
        exp_q.push_back(d);
    endtask

    task automatic do_read(input string tag);
        logic [7:0] e;
        drive(1'b0, 1'b1, 8'h00);
        check({tag, " rvalid"}, 32'(rvalid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard underrun"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, " data"}, 32'(data_out), 32'(e));
        end
    endtask

    task automatic do_both(input logic [7:0] d, input string tag);
        logic [7:0] e;
        drive(1'b1, 1'b1, d);
        check({tag, " rvalid"}, 32'(rvalid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard underrun"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, " data"}, 32'(data_out), 32'(e));
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        data_in = 8'h00;

        //            we    re    din    dout   rv    cnt   emp   full  ovf   unf
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 8'h41, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 8'h42, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 8'h43, 8'h00, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'h41, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 8'h00, 8'h42, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'h00, 8'h43, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h43, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 8'h55, 8'h43, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 8'h66, 8'h55, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 8'h66, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        do_reset();
        check("reset empty", 32'(empty), 32'd1);
        check("reset count", 32'(count), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset full", 32'(full), 32'd0);
        check("reset rvalid", 32'(rvalid), 32'd0);
        check("reset data_out", 32'(data_out), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset underflow", 32'(underflow), 32'd0);

        // Table-driven single-cycle vectors
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].we, vecs[i].re, vecs[i].din);
            check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].dout));
            check($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'(vecs[i].rvalid));
            check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].count));
            check($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].empty));
            check($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].full));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].full));
            check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
            check($sformatf("vec%0d underflow", i), 32'(underflow), 32'(vecs[i].unf));
        end

        // Fill, overflow, full simultaneous op, drain
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_write(8'(i));
            check($sformatf("fill%0d count", i), 32'(count), 32'(i + 1));
        end
        check("fill full", 32'(full), 32'd1);
        check("fill busy", 32'(busy), 32'd1);
        check("fill overflow pre", 32'(overflow), 32'd0);
        drive(1'b1, 1'b0, 8'hFF);
        check("ovf flag", 32'(overflow), 32'd1);
        check("ovf count", 32'(count), 32'd16);
        do_both(8'hEE, "full_both");
        check("full_both count", 32'(count), 32'd15);
        check("full_both overflow", 32'(overflow), 32'd1);
        check("full_both full", 32'(full), 32'd0);
        for (int i = 0; i < 15; i++) begin
            do_read($sformatf("drain%0d", i));
        end
        check("drain empty", 32'(empty), 32'd1);
        check("drain count", 32'(count), 32'd0);
        idle();
        check("drain rvalid single", 32'(rvalid), 32'd0);
        check("drain underflow", 32'(underflow), 32'd0);

        // Wrap-around
        do_reset();
        for (int i = 0; i < 12; i++) do_write(8'(8'h10 + i));
        for (int i = 0; i < 12; i++) do_read($sformatf("wrapA%0d", i));
        for (int i = 0; i < 10; i++) do_write(8'(8'hA0 + i));
        check("wrap count", 32'(count), 32'd10);
        for (int i = 0; i < 10; i++) do_read($sformatf("wrapB%0d", i));
        check("wrap empty", 32'(empty), 32'd1);

        // Simultaneous read/write at count 5
        do_reset();
        for (int i = 0; i < 5; i++) do_write(8'(8'h30 + i));
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'(8'hC0 + i));
            do_both(8'(8'hC0 + i), $sformatf("both%0d", i));
            check($sformatf("both%0d count", i), 32'(count), 32'd5);
        end
        for (int i = 0; i < 5; i++) do_read($sformatf("bothdrain%0d", i));
        check("both empty", 32'(empty), 32'd0 + 32'd1);

        // Mid-stream reset with a write in the same cycle
        do_reset();
        for (int i = 0; i < 7; i++) do_write(8'(8'h70 + i));
        check("mid count pre", 32'(count), 32'd7);
        @(negedge clk);
        reset   = 1'b0;
        we      = 1'b1;
        re      = 1'b0;
        data_in = 8'h99;
        @(posedge clk);
        #1;
        check("mid count", 32'(count), 32'd0);
        check("mid empty", 32'(empty), 32'd1);
        check("mid rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        we    = 1'b0;
        exp_q.delete();
        drive(1'b0, 1'b1, 8'h00);
        check("post-mid rvalid", 32'(rvalid), 32'd0);
        check("post-mid underflow", 32'(underflow), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_buffer.md
# fifo_buffer

Synchronous byte FIFO that sits directly downstream of the UART-receive stage. It accepts bytes on a single-cycle write strobe and reports `busy` so the producer holds off while the buffer is full. It also presents buffered bytes to a downstream consumer (TX/display stage) through a read-request / read-valid handshake. Sticky overflow and underflow flags expose protocol violations for debug.

## Interface
- `DATA_W`, 8, byte width of each entry
- `ADDR_W`, 4, pointer width; depth = 2^ADDR_W (16 entries by default)

- `clk`  in  1  single system clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-low reset
- `data_in`  in  DATA_W  byte to store; sampled when `we`=1
- `we`  in  1  write strobe, one-cycle pulse per byte
- `busy`  out  1  high when the FIFO cannot accept a write (equals `full`)
- `re`  in  1  read request, one cycle per byte
- `data_out`  out  DATA_W  registered read data, valid when `rvalid`=1
- `rvalid`  out  1  one-cycle pulse, one cycle after an accepted read
- `empty`  out  1  no entries stored
- `full`  out  1  2^ADDR_W entries stored
- `count`  out  ADDR_W+1  current occupancy, 0..2^ADDR_W
- `overflow`  out  1  sticky; set by a write attempted while full
- `underflow`  out  1  sticky; set by a read attempted while empty

## Operation
- Storage: a 2^ADDR_W × DATA_W array, with write pointer `wp`, read pointer `rp` and occupancy counter `count`, all ADDR_W or ADDR_W+1 wide.
- Pointers wrap modulo 2^ADDR_W with natural binary rollover (15→0 at default depth).
- `empty` = (`count`==0). `full` = (`count`==2^ADDR_W). Both and `busy` are combinational from the registered `count`.
- Write accepted when `we`=1 and `full`=0:
  - `mem[wp]` ← `data_in`
  - `wp` ← `wp`+1
- Write attempted while `full`=1 is dropped. Memory and `wp` are unchanged and `overflow` ← 1.
- Read accepted when `re`=1 and `empty`=0:
  - `data_out` ← `mem[rp]`
  - `rp` ← `rp`+1
  - `rvalid` ← 1 next cycle
- Read attempted while `empty`=1 is dropped. `data_out` holds its value, `rvalid` stays 0 and `underflow` ← 1.
- `count` update per cycle:
  - +1 on an accepted write only
  - −1 on an accepted read only
  - unchanged when both are accepted, or neither
- Simultaneous `we` and `re` rules:
  - Non-empty and non-full: both accepted, `count` unchanged.
  - Full: read accepted, write rejected (overflow set). Acceptance is decided on the pre-edge `full`, never on the slot being freed this cycle.
  - Empty: write accepted, read rejected (underflow set). The new byte is not bypassed to `data_out`.
- `data_out` holds the last read byte until the next accepted read.
- `overflow`/`underflow` clear only on reset.
- Memory contents are not reset; contents are undefined until written.

## Timing
- Reset (`reset`=0 at a rising edge) gives:
  - `wp`=`rp`=0, `count`=0, `empty`=1, `full`=0, `busy`=0
  - `data_out`=0, `rvalid`=0, `overflow`=0, `underflow`=0
- Reset takes priority over `we`/`re` in the same cycle, and a reset mid-stream discards all stored bytes.
- Write latency:
  - A byte written at edge N is readable by a `re` sampled at edge N+1 (`empty` falls after edge N).
  - `busy` rises in the cycle after the write that fills the FIFO.
- Read latency: `re` sampled at edge N gives `data_out` and `rvalid`=1 after edge N. `rvalid` lasts exactly one cycle per accepted read.
- Throughput: one write and one read per cycle sustained. The producer's `we` pulse (issued only while `busy`=0) is always accepted.
- `count` reflects all accepted operations at edge N immediately after edge N.

## Test plan
- Reset then idle: `reset`=0 for 2 cycles → `empty`=1, `count`=0, `busy`=0, `rvalid`=0, flags 0.
- Write 0x41, 0x42, 0x43 on consecutive cycles, then three `re` pulses → `data_out` gives 0x41, 0x42, 0x43 with `rvalid` on each, then `empty`=1 and `count`=0.
- Fill with 16 writes (0x00..0x0F) → `full`=`busy`=1 and `count`=16. Then a 17th write of 0xFF → `overflow`=1 and `count` stays 16. Draining yields 0x00..0x0F with no 0xFF.
- `re` while empty after reset → `underflow`=1, `rvalid`=0, `data_out`=0x00.
- Wrap-around: 12 writes, 12 reads, then 10 writes of 0xA0..0xA9 (`wp` wraps) → the reads return 0xA0..0xA9 in order.
- Simultaneous ops:
  - With `count`=5, `we`+`re` for 4 cycles → `count` stays 5 and FIFO order is preserved.
  - With full, `we`+`re` → read accepted, `count`=15, `overflow`=1.
  - Assert `reset` mid-stream with `count`=7 → `count`=0 and `empty`=1 next cycle.
